snake_key_turn_queue: RTL and testbench

//  Player-input front end for the snake game core. Synchronises and debounces the
//  two active-low push keys and turns each clean press into a turn command
//  (0 = right/KEY[0], 1 = left/KEY[1]). Commands are buffered in a small FIFO and

---
 rtl/snake_key_turn_queue_if.sv | 21 ++
 rtl/snake_key_turn_queue.sv | 112 +++++++++++
 tb/tb_snake_key_turn_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/snake_key_turn_queue_if.sv
// Turn-command handshake between the key front end (master) and the snake game core (slave).
interface snake_key_turn_queue_if;
    logic turn_valid;
    logic turn_dir;
    logic turn_ack;
    logic move_tick;

    modport master (
        output turn_valid,
        output turn_dir,
        input  turn_ack,
        input  move_tick
    );

    modport slave (
        input  turn_valid,
        input  turn_dir,
        output turn_ack,
        output move_tick
    );
endinterface

// File: rtl/snake_key_turn_queue.sv
// Key synchroniser/debouncer feeding a small turn-command FIFO that the game core
// drains at most once per snake move.
module snake_key_turn_queue #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int FIFO_DEPTH      = 2,
    parameter int DROP_W          = 8
) (
    input  logic                          clockInp,
    input  logic                          rst_n,
    input  logic [1:0]                    KEY,
    snake_key_turn_queue_if.master        turn_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       key_s1, key_s2, key_stable;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [1:0]       deb_done, press;

    logic             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             permit;
    logic             turn_valid;
    logic             ev_valid, ev_dir, ev_both;
    logic             pop, push, full;
    logic [1:0]       drop_add;
    logic [DROP_W+1:0] drop_sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        deb_done = '0;
        press    = '0;
        for (int k = 0; k < 2; k++) begin
            deb_done[k] = (key_s2[k] != key_stable[k]) &&
                          (deb_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1));
            press[k]    = deb_done[k] && !key_s2[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clockInp or negedge rst_n) begin
        if (!rst_n) begin
            key_s1     <= '1;
            key_s2     <= '1;
            key_stable <= '1;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k] == key_stable[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_done[k]) begin
                    key_stable[k] <= key_s2[k];
                    deb_cnt[k]    <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Right key wins a simultaneous press; the left press is counted as dropped.
    always_comb begin
        ev_valid = |press;
        ev_dir   = !press[0];
        ev_both  = &press;
        full     = (fifo_level == LVL_W'(FIFO_DEPTH));
        pop      = turn_valid && turn_bus.turn_ack;
        push     = ev_valid && (!full || pop);
        drop_add = {1'b0, ev_valid && !push} + {1'b0, ev_both};
        drop_sum = {2'b00, drop_cnt} + {{DROP_W{1'b0}}, drop_add};
    end

    assign turn_valid          = (fifo_level != '0) && permit;
    assign turn_bus.turn_valid = turn_valid;
    assign turn_bus.turn_dir   = (fifo_level != '0) ? fifo_mem[rd_ptr] : 1'b0;

    // NOTE: the storage array is not reset; its contents are masked by fifo_level.
    always_ff @(posedge clockInp) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ev_dir;
        end
    end

    always_ff @(posedge clockInp or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            permit     <= 1'b1;
            drop_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            // A move_tick re-arms the permit even when it coincides with a pop.
            if (turn_bus.move_tick) permit <= 1'b1;
            else if (pop)           permit <= 1'b0;
            if (drop_sum > {2'b00, {DROP_W{1'b1}}}) drop_cnt <= '1;
            else                                   drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end
endmodule

// File: tb/tb_snake_key_turn_queue.sv
// Directed bench for snake_key_turn_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=2, DROP_W=2.
module tb_snake_key_turn_queue;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] fifo_level;
    logic [1:0] drop_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    snake_key_turn_queue_if tif ();

    snake_key_turn_queue #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (2),
        .DROP_W          (2)
    ) dut (
        .clockInp   (clk),
        .rst_n      (rst_n),
        .KEY        (key),
        .turn_bus   (tif),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] key;
        logic       tick;
        logic       ack;
        logic       exp_valid;
        logic       exp_dir;
        logic [1:0] exp_level;
        logic [1:0] exp_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(logic [1:0] k, logic t, logic a,
                                    logic v, logic d, logic [1:0] l, logic [1:0] dr);
        vec_t x;
        x.key = k; x.tick = t; x.ack = a;
        x.exp_valid = v; x.exp_dir = d; x.exp_level = l; x.exp_drop = dr;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic d,
                             input logic [1:0] l, input logic [1:0] dr);
        check({tag, ".valid"}, 32'(tif.turn_valid), 32'(v));
        check({tag, ".dir"},   32'(tif.turn_dir),   32'(d));
        check({tag, ".level"}, 32'(fifo_level),     32'(l));
        check({tag, ".drop"},  32'(drop_cnt),       32'(dr));
    endtask

    task automatic step(input logic [1:0] k, input logic t, input logic a);
        key           = k;
        tif.move_tick = t;
        tif.turn_ack  = a;
        @(posedge clk);
        #1;
    endtask

    // One debounced press of key kk: held low 8 cycles, then released 8 cycles.
    task automatic press(input int kk, input logic a);
        logic [1:0] k;
        k = (kk == 0) ? 2'b10 : 2'b01;
        repeat (8) step(k, 1'b0, a);
        repeat (8) step(2'b11, 1'b0, a);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        key           = 2'b11;
        tif.move_tick = 1'b0;
        tif.turn_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Single press with ack tied high: valid for exactly one cycle after edge 6.
        for (int i = 0; i < 20; i++)
            add_vec(2'b10, 1'b0, 1'b1, i == 5, 1'b0, (i == 5) ? 2'd1 : 2'd0, 2'd0);
        for (int i = 0; i < 8; i++)
            add_vec(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        // Left-key glitches three cycles long never produce an event.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 3; i++) add_vec(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
            for (int i = 0; i < 3; i++) add_vec(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        end
        for (int i = 0; i < 6; i++)
            add_vec(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

        do_reset();
        check_out("reset", 1'b0, 1'b0, 2'd0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].key, vecs[i].tick, vecs[i].ack);
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_dir,
                      vecs[i].exp_level, vecs[i].exp_drop);
        end
        check("glitch.deb_cnt1", 32'(dut.deb_cnt[1]), 32'd0);

        // R, L, R with ack held low: third press dropped; then one pop per move_tick.
        do_reset();
        press(0, 1'b0); press(1, 1'b0); press(0, 1'b0);
        check_out("rlr.queued", 1'b1, 1'b0, 2'd2, 2'd1);
        step(2'b11, 1'b0, 1'b1);
        check_out("rlr.pop1", 1'b0, 1'b1, 2'd1, 2'd1);
        repeat (2) step(2'b11, 1'b0, 1'b0);
        check_out("rlr.wait", 1'b0, 1'b1, 2'd1, 2'd1);
        step(2'b11, 1'b1, 1'b0);
        check_out("rlr.tick", 1'b1, 1'b1, 2'd1, 2'd1);
        step(2'b11, 1'b0, 1'b1);
        check_out("rlr.pop2", 1'b0, 1'b0, 2'd0, 2'd1);

        // Both keys fall together and stay low: one right event, left dropped.
        do_reset();
        repeat (5) step(2'b00, 1'b0, 1'b0);
        check_out("both.pre", 1'b0, 1'b0, 2'd0, 2'd0);
        step(2'b00, 1'b0, 1'b0);
        check_out("both.edge6", 1'b1, 1'b0, 2'd1, 2'd1);
        repeat (10) step(2'b00, 1'b0, 1'b0);
        check_out("both.held", 1'b1, 1'b0, 2'd1, 2'd1);
        repeat (8) step(2'b11, 1'b0, 1'b0);
        check_out("both.released", 1'b1, 1'b0, 2'd1, 2'd1);

        // Ack held high without move_tick pops once; tick re-arms; tick+pop keeps permit.
        do_reset();
        press(0, 1'b0); press(1, 1'b0);
        check_out("permit.queued", 1'b1, 1'b0, 2'd2, 2'd0);
        step(2'b11, 1'b0, 1'b1);
        check_out("permit.pop1", 1'b0, 1'b1, 2'd1, 2'd0);
        repeat (3) step(2'b11, 1'b0, 1'b1);
        check_out("permit.held", 1'b0, 1'b1, 2'd1, 2'd0);
        step(2'b11, 1'b1, 1'b1);
        check_out("permit.tick", 1'b1, 1'b1, 2'd1, 2'd0);
        step(2'b11, 1'b0, 1'b1);
        check_out("permit.pop2", 1'b0, 1'b0, 2'd0, 2'd0);
        press(1, 1'b0); press(0, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        check_out("coinc.armed", 1'b1, 1'b1, 2'd2, 2'd0);
        step(2'b11, 1'b1, 1'b1);
        check_out("coinc.pop_tick", 1'b1, 1'b0, 2'd1, 2'd0);
        step(2'b11, 1'b0, 1'b1);
        check_out("coinc.pop2", 1'b0, 1'b0, 2'd0, 2'd0);

        // Empty FIFO: push and ack on the same edge, ack is ignored.
        do_reset();
        repeat (5) step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b1);
        check_out("empty_push_ack", 1'b1, 1'b0, 2'd1, 2'd0);

        // Full FIFO: push and pop on the same edge, no drop.
        do_reset();
        press(0, 1'b0); press(1, 1'b0);
        repeat (5) step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b1);
        check_out("full_push_pop", 1'b0, 1'b1, 2'd2, 2'd0);

        // Reset mid-queue with KEY[0] held low through release.
        do_reset();
        press(0, 1'b0); press(1, 1'b0);
        repeat (2) step(2'b10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("midrst.async", 1'b0, 1'b0, 2'd0, 2'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step(2'b10, 1'b0, 1'b0);
        check_out("midrst.pre", 1'b0, 1'b0, 2'd0, 2'd0);
        step(2'b10, 1'b0, 1'b0);
        check_out("midrst.edge6", 1'b1, 1'b0, 2'd1, 2'd0);
        repeat (10) step(2'b10, 1'b0, 1'b0);
        check_out("midrst.held", 1'b1, 1'b0, 2'd1, 2'd0);

        // Drop counter saturates at 3 with a 2-bit counter.
        do_reset();
        press(0, 1'b0); press(0, 1'b0);
        press(0, 1'b0);
        check_out("sat.drop1", 1'b1, 1'b0, 2'd2, 2'd1);
        press(0, 1'b0); press(0, 1'b0);
        check_out("sat.drop3", 1'b1, 1'b0, 2'd2, 2'd3);
        press(1, 1'b0);
        check_out("sat.hold", 1'b1, 1'b0, 2'd2, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
